// File: rtl/pio_ctrl.sv
// Host register file and IRQ/forced-instruction control for a bank of NSM
// programmable I/O state machines. Instruction memory is shared by all SMs.
//
// imm state (per SM) | meaning
// -------------------|-------------------------------------------------------
// IMM_IDLE           | no forced instruction waiting for this SM
// IMM_PEND           | imm_instr holds an instruction for the SM's next tick
module pio_ctrl #(
    parameter int NSM = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [5:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [NSM-1:0]     penable,
    input  logic [5*NSM-1:0]   pc_flat,
    input  logic [8*NSM-1:0]   irq_set,
    input  logic [8*NSM-1:0]   irq_clr,
    output logic [NSM-1:0]     sm_en,
    output logic [NSM-1:0]     sm_restart,
    output logic [NSM-1:0]     div_restart,
    output logic [NSM-1:0]     imm,
    output logic [16*NSM-1:0]  imm_instr,
    output logic [16*NSM-1:0]  instr_flat,
    output logic [7:0]         irq_flags,
    output logic [1:0]         irq_out
);

    localparam logic [5:0] ADDR_CTRL  = 6'h20;
    localparam logic [5:0] ADDR_IRQ   = 6'h21;
    localparam logic [5:0] ADDR_FORCE = 6'h22;
    localparam logic [5:0] ADDR_INTE  = 6'h23;
    localparam logic [5:0] ADDR_SM0   = 6'h24;

    typedef enum logic {
        IMM_IDLE = 1'b0,
        IMM_PEND = 1'b1
    } imm_state_t;

    logic [15:0]    mem [32];
    logic           wr_mem, wr_ctrl, wr_irq, wr_force, wr_inte;
    logic [NSM-1:0] wr_sm;
    logic [7:0]     set_any, clr_any, flags_nxt;
    logic [3:0]     inte0, inte1;
    logic [31:0]    rd_val;
    imm_state_t     imm_state     [NSM];
    imm_state_t     imm_state_nxt [NSM];
    logic           unused_wdata;

    assign unused_wdata = ^wdata[31:16];

    // Address decode
    always_comb begin
        wr_mem   = wr_en && !addr[5];
        wr_ctrl  = wr_en && (addr == ADDR_CTRL);
        wr_irq   = wr_en && (addr == ADDR_IRQ);
        wr_force = wr_en && (addr == ADDR_FORCE);
        wr_inte  = wr_en && (addr == ADDR_INTE);
        wr_sm    = '0;
        for (int n = 0; n < NSM; n++) begin
            wr_sm[n] = wr_en && (addr == ADDR_SM0 + 6'(n));
        end
    end

    // Instruction memory is deliberately not reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (!reset && wr_mem) begin
            mem[addr[4:0]] <= wdata[15:0];
        end
    end

    always_comb begin
        for (int n = 0; n < NSM; n++) begin
            instr_flat[16*n +: 16] = mem[pc_flat[5*n +: 5]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sm_en       <= '0;
            sm_restart  <= '0;
            div_restart <= '0;
        end else begin
            sm_restart  <= '0;
            div_restart <= '0;
            if (wr_ctrl) begin
                sm_en       <= wdata[NSM-1:0];
                sm_restart  <= wdata[4 +: NSM];
                div_restart <= wdata[8 +: NSM];
            end
        end
    end

    // Flag update order: host W1C, SM clears, SM sets, host force.
    always_comb begin
        set_any = '0;
        clr_any = '0;
        for (int n = 0; n < NSM; n++) begin
            set_any = set_any | irq_set[8*n +: 8];
            clr_any = clr_any | irq_clr[8*n +: 8];
        end
        flags_nxt = irq_flags;
        if (wr_irq) begin
            flags_nxt = flags_nxt & ~wdata[7:0];
        end
        flags_nxt = flags_nxt & ~clr_any;
        flags_nxt = flags_nxt | set_any;
        if (wr_force) begin
            flags_nxt = flags_nxt | wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flags <= '0;
            inte0     <= '0;
            inte1     <= '0;
            irq_out   <= '0;
        end else begin
            irq_flags <= flags_nxt;
            irq_out   <= {|(irq_flags[3:0] & inte1), |(irq_flags[3:0] & inte0)};
            if (wr_inte) begin
                inte0 <= wdata[3:0];
                inte1 <= wdata[11:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imm_instr <= '0;
        end else begin
            for (int n = 0; n < NSM; n++) begin
                if (wr_sm[n]) begin
                    imm_instr[16*n +: 16] <= wdata[15:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NSM; n++) begin
                imm_state[n] <= IMM_IDLE;
            end
        end else begin
            for (int n = 0; n < NSM; n++) begin
                imm_state[n] <= imm_state_nxt[n];
            end
        end
    end

    // A fresh write always re-arms, even on a consuming tick or restart.
    always_comb begin
        for (int n = 0; n < NSM; n++) begin
            imm_state_nxt[n] = imm_state[n];
            unique case (imm_state[n])
                IMM_IDLE: begin
                    if (wr_sm[n]) begin
                        imm_state_nxt[n] = IMM_PEND;
                    end
                end
                IMM_PEND: begin
                    if (wr_sm[n]) begin
                        imm_state_nxt[n] = IMM_PEND;
                    end else if (sm_restart[n]) begin
                        imm_state_nxt[n] = IMM_IDLE;
                    end else if (penable[n] && sm_en[n]) begin
                        imm_state_nxt[n] = IMM_IDLE;
                    end
                end
                default: imm_state_nxt[n] = IMM_IDLE;
            endcase
            imm[n] = (imm_state[n] == IMM_PEND);
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_CTRL: rd_val[NSM-1:0] = sm_en;
            ADDR_IRQ:  rd_val[7:0]     = irq_flags;
            ADDR_INTE: begin
                rd_val[3:0]  = inte0;
                rd_val[11:8] = inte1;
            end
            default: begin
                for (int n = 0; n < NSM; n++) begin
                    if (addr == ADDR_SM0 + 6'(n)) begin
                        rd_val[15:0] = imm_instr[16*n +: 16];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_pio_ctrl.sv
// Randomized bench for pio_ctrl: a cycle-level reference model of the register
// map, IRQ flag rules and forced-instruction handshake is compared every cycle.
module tb_pio_ctrl;
    localparam int NSM = 4;

    logic              clk = 1'b0;
    logic              reset, wr_en, rd_en;
    logic [5:0]        addr;
    logic [31:0]       wdata, rdata;
    logic [NSM-1:0]    penable, sm_en, sm_restart, div_restart, imm;
    logic [5*NSM-1:0]  pc_flat;
    logic [8*NSM-1:0]  irq_set, irq_clr;
    logic [16*NSM-1:0] imm_instr, instr_flat;
    logic [7:0]        irq_flags;
    logic [1:0]        irq_out;

    pio_ctrl #(.NSM(NSM)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .penable(penable), .pc_flat(pc_flat),
        .irq_set(irq_set), .irq_clr(irq_clr), .sm_en(sm_en),
        .sm_restart(sm_restart), .div_restart(div_restart), .imm(imm),
        .imm_instr(imm_instr), .instr_flat(instr_flat), .irq_flags(irq_flags),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    logic [15:0] m_mem [32];
    logic [3:0]  m_en, m_rst, m_div, m_pend, m_ie0, m_ie1;
    logic [15:0] m_ins [NSM];
    logic [7:0]  m_flags;
    logic [1:0]  m_iout;
    logic [31:0] m_rdata;
    bit          mem_ok = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(logic [5:0] a);
        logic [31:0] v = 32'h0;
        if (a == 6'h20) v = {28'h0, m_en};
        else if (a == 6'h21) v = {24'h0, m_flags};
        else if (a == 6'h23) v = {20'h0, m_ie1, 4'h0, m_ie0};
        else if (a >= 6'h24 && a < 6'h24 + NSM) v = {16'h0, m_ins[a - 6'h24]};
        return v;
    endfunction

    task automatic cycle();
        logic [3:0]  n_en = m_en, n_rst = 4'h0, n_div = 4'h0, n_pend = m_pend;
        logic [3:0]  n_ie0 = m_ie0, n_ie1 = m_ie1;
        logic [15:0] n_ins [NSM];
        logic [7:0]  f = m_flags;
        logic [1:0]  n_iout;
        logic [31:0] n_rdata = m_rdata;
        bit          mem_wr = 0;
        for (int n = 0; n < NSM; n++) n_ins[n] = m_ins[n];
        n_iout = {((m_flags[3:0] & m_ie1) != 0), ((m_flags[3:0] & m_ie0) != 0)};
        if (reset) begin
            n_en = 0; n_pend = 0; n_ie0 = 0; n_ie1 = 0; f = 0; n_iout = 0; n_rdata = 0;
            for (int n = 0; n < NSM; n++) n_ins[n] = 16'h0;
        end else begin
            if (rd_en) n_rdata = model_read(addr);
            if (wr_en && addr == 6'h21) f = f & ~wdata[7:0];
            for (int n = 0; n < NSM; n++) f = f & ~irq_clr[8*n +: 8];
            for (int n = 0; n < NSM; n++) f = f | irq_set[8*n +: 8];
            if (wr_en && addr == 6'h22) f = f | wdata[7:0];
            if (wr_en && addr < 6'h20) mem_wr = 1;
            if (wr_en && addr == 6'h20) begin
                n_en = wdata[3:0]; n_rst = wdata[7:4]; n_div = wdata[11:8];
            end
            if (wr_en && addr == 6'h23) begin
                n_ie0 = wdata[3:0]; n_ie1 = wdata[11:8];
            end
            for (int n = 0; n < NSM; n++) begin
                if (wr_en && addr == 6'h24 + 6'(n)) begin
                    n_pend[n] = 1; n_ins[n] = wdata[15:0];
                end else if (m_rst[n]) n_pend[n] = 0;
                else if (m_pend[n] && penable[n] && m_en[n]) n_pend[n] = 0;
            end
        end
        if (mem_wr) m_mem[addr[4:0]] = wdata[15:0];
        @(posedge clk);
        #1;
        m_en = n_en; m_rst = n_rst; m_div = n_div; m_pend = n_pend;
        m_ie0 = n_ie0; m_ie1 = n_ie1; m_flags = f; m_iout = n_iout; m_rdata = n_rdata;
        for (int n = 0; n < NSM; n++) m_ins[n] = n_ins[n];
        check("sm_en", 64'(sm_en), 64'(m_en));
        check("sm_restart", 64'(sm_restart), 64'(m_rst));
        check("div_restart", 64'(div_restart), 64'(m_div));
        check("imm", 64'(imm), 64'(m_pend));
        check("imm_instr", 64'(imm_instr), {m_ins[3], m_ins[2], m_ins[1], m_ins[0]});
        check("irq_flags", 64'(irq_flags), 64'(m_flags));
        check("irq_out", 64'(irq_out), 64'(m_iout));
        check("rdata", 64'(rdata), 64'(m_rdata));
        if (mem_ok) begin
            for (int n = 0; n < NSM; n++)
                check("instr_flat", 64'(instr_flat[16*n +: 16]), 64'(m_mem[pc_flat[5*n +: 5]]));
        end
    endtask

    task automatic host_wr(logic [5:0] a, logic [31:0] d);
        wr_en = 1; addr = a; wdata = d;
        cycle();
        wr_en = 0;
    endtask

    initial begin
        int cnt;
        reset = 1; wr_en = 0; rd_en = 0; addr = 0; wdata = 0;
        penable = 0; pc_flat = 0; irq_set = 0; irq_clr = 0;
        m_en = 0; m_rst = 0; m_div = 0; m_pend = 0; m_ie0 = 0; m_ie1 = 0;
        m_flags = 0; m_iout = 0; m_rdata = 0;
        for (int n = 0; n < NSM; n++) m_ins[n] = 0;
        cycle();
        cycle();
        reset = 0;
        for (int i = 0; i < 32; i++) host_wr(6'(i), $urandom);
        mem_ok = 1;

        // program memory lookup and CTRL pulses
        pc_flat[9:5] = 5'd3;
        host_wr(6'h03, 32'h0000_E081);
        check("instr_sm1", 64'(instr_flat[31:16]), 64'hE081);
        host_wr(6'h20, 32'h0000_00F5);
        check("ctrl_en", 64'(sm_en), 64'h5);
        check("ctrl_restart", 64'(sm_restart), 64'hF);
        cycle();
        check("restart_clear", 64'(sm_restart), 64'h0);

        // forced instruction held until the consuming tick
        host_wr(6'h20, 32'h0000_0004);
        host_wr(6'h26, 32'h0000_A042);
        cnt = int'(imm[2]);
        for (int i = 0; i < 3; i++) begin
            cycle();
            cnt += int'(imm[2]);
        end
        penable = 4'b0100;
        cycle();
        penable = 0;
        check("imm2_len", 64'(cnt), 64'd4);
        check("imm2_done", 64'(imm[2]), 64'h0);
        check("imm2_instr", 64'(imm_instr[47:32]), 64'hA042);

        // last write wins before the tick
        host_wr(6'h20, 32'h0000_0005);
        host_wr(6'h24, 32'h0000_1111);
        host_wr(6'h24, 32'h0000_2222);
        check("imm0_instr", 64'(imm_instr[15:0]), 64'h2222);
        penable = 4'b0001;
        cycle();
        penable = 0;
        check("imm0_done", 64'(imm[0]), 64'h0);

        // set beats clear; irq_out follows one cycle later
        host_wr(6'h23, 32'h0000_0001);
        irq_set = 32'h0000_0001; irq_clr = 32'h0000_0100;
        host_wr(6'h21, 32'h0000_0001);
        irq_set = 0; irq_clr = 0;
        check("flag0", 64'(irq_flags[0]), 64'h1);
        cycle();
        check("irq_out0", 64'(irq_out[0]), 64'h1);

        // reset while busy
        host_wr(6'h25, 32'h0000_1234);
        host_wr(6'h22, 32'h0000_00FF);
        reset = 1;
        cycle();
        reset = 0;
        check("rst_imm", 64'(imm), 64'h0);
        check("rst_flags", 64'(irq_flags), 64'h0);
        check("rst_iout", 64'(irq_out), 64'h0);
        cycle();
        check("mem_kept", 64'(instr_flat[31:16]), 64'hE081);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            wr_en   = ($urandom_range(0, 9) < 3);
            rd_en   = ($urandom_range(0, 9) < 3);
            addr    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'(6'h20 + 6'($urandom_range(0, 7)));
            wdata   = $urandom;
            penable = 4'($urandom);
            pc_flat = 20'($urandom);
            irq_set = $urandom & $urandom & $urandom;
            irq_clr = $urandom & $urandom & $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
